fft_addr_gen: RTL and testbench
===============================

// Module: fft_addr_gen
// PURPOSE
//   Upstream sequencer for the radix-2 in-place FFT butterfly datapath. For an
//   N=2^LOG_N point transform it walks every stage and butterfly and emits one
//   read-address pair, one twiddle address and a 3-bit twiddle mode code per
//   butterfly over a valid/ready handshake. The mode code drives the downstream
//   twiddle-select decoder, which acts on codes 000, 001 and 100.
// PARAMETERS
//   LOG_N   10       log2 of transform size N; legal range 2..10
//   ADDR_W  LOG_N    sample address width
// PORTS
//   clk        in   1         single clock; all state updates on rising edge
//   rst_n      in   1         asynchronous active-low reset
//   start      in   1         begin transform; sampled only in IDLE
//   out_ready  in   1         downstream accepts the current butterfly
//   out_valid  out  1         addr_a/addr_b/tw_addr/stage/mode are valid
//   addr_a     out  ADDR_W    top butterfly input address
//   addr_b     out  ADDR_W    bottom butterfly input address (addr_a + span)
//   tw_addr    out  ADDR_W-1  twiddle ROM index, 0..N/2-1
//   stage      out  4         current stage s, 0..LOG_N-1
//   mode       out  3         twiddle class: 000 W=1, 001 W=-j, 100 general
//   busy       out  1         high in RUN
//   done       out  1         one-cycle pulse after the last butterfly transfer
// BEHAVIOUR
//   - Reset: FSM=IDLE, k=0, s=0. All outputs 0, including out_valid, busy and done.
//   - FSM: IDLE -(start)-> RUN -(last transfer)-> DONE -(1 cycle)-> IDLE.
//   - start is ignored in RUN and DONE; there is no restart mid-transform.
//   - Outputs are registered. If start is high at edge t, then out_valid=1 and
//     busy=1 from edge t+1, with k=0 and s=0 presented.
//   - Transfer occurs when out_valid && out_ready. Without a transfer, all
//     outputs hold stable and out_valid stays high. There is no combinational
//     path from out_ready to any output.
//   - On a transfer: k <= k+1. If k==N/2-1, then k <= 0 and s <= s+1.
//     The next butterfly is presented in the following cycle, which gives
//     1 butterfly/cycle throughput under continuous ready.
//   - Last transfer (s==LOG_N-1, k==N/2-1): next cycle out_valid=0, busy=0,
//     done=1 (DONE). The cycle after that returns to IDLE with done=0.
//   - Total transfers per transform: LOG_N*N/2.
//   - Address math, span = 1<<s:
//       addr_a  = ((k>>s)<<(s+1)) | (k & (span-1))   (a 0 inserted at bit s)
//       addr_b  = addr_a | span
//       tw_addr = (k & (span-1)) << (LOG_N-1-s)
//     All results are unsigned and fit their port widths; no wrap is possible.
//   - mode: 3'b000 if tw_addr==0; 3'b001 if tw_addr==N/4; otherwise 3'b100.
//     No other codes are ever emitted.
//   - stage output equals s, zero-extended to 4 bits.
//   - Asynchronous reset asserted mid-RUN returns immediately to the reset state.
//     The partial transform is abandoned; no done pulse is produced.
// TESTING  (LOG_N=3, N=8 unless noted)
//   1 Reset: assert rst_n=0 mid-RUN -> out_valid=0, busy=0, done=0 and all
//     outputs 0 immediately (before the next clk edge); after release, FSM is
//     IDLE and a new start is accepted.
//   2 start, out_ready=1 -> exact sequence of (addr_a,addr_b,tw,mode):
//     s0: (0,1,0,000)(2,3,0,000)(4,5,0,000)(6,7,0,000)
//     s1: (0,2,0,000)(1,3,2,001)(4,6,0,000)(5,7,2,001)
//     s2: (0,4,0,000)(1,5,1,100)(2,6,2,001)(3,7,3,100)
//     then done=1 for exactly one cycle, 12 transfers in total.
//   3 Backpressure: out_ready low for 5 cycles at s1,k=1 -> (1,3,2,001) held
//     stable with out_valid=1; sequence resumes unchanged afterwards.
//   4 start pulsed during RUN and during DONE -> ignored; transfer count still
//     12 and only one done pulse.
//   5 LOG_N=10, random out_ready -> 5120 transfers; every address pair appears
//     exactly once per stage; addr_b-addr_a == 1<<s; done asserted once.
//   6 Back-to-back: start high in the cycle after DONE -> new transform begins;
//     first output is (0,1,0,000) at s=0.

Source files
------------

// File: rtl/fft_addr_gen_if.sv
// Butterfly output bus of the FFT address generator: one address pair, twiddle
// index, stage and twiddle class per beat, under a valid/ready handshake.
interface fft_addr_gen_if #(
  parameter int LOG_N  = 10,
  parameter int ADDR_W = LOG_N
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-2:0] tw_addr;
  logic [3:0]        stage;
  logic [2:0]        mode;

  modport master (
    output out_valid, addr_a, addr_b, tw_addr, stage, mode,
    input  out_ready
  );

  modport slave (
    input  out_valid, addr_a, addr_b, tw_addr, stage, mode,
    output out_ready
  );
endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT sequencer: walks every stage/butterfly and presents one
// registered address pair, twiddle index and twiddle class per transfer.
module fft_addr_gen #(
  parameter int LOG_N  = 10,
  parameter int ADDR_W = LOG_N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  fft_addr_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]        LAST_S  = 4'(LOG_N - 1);
  localparam logic [ADDR_W-2:0] QUARTER = (ADDR_W-1)'(1) << (LOG_N - 2);

  state_t            state;
  logic [ADDR_W-2:0] k;
  logic [3:0]        s;

  logic              wrap_k;
  logic              is_last;
  logic [ADDR_W-2:0] nxt_k;
  logic [3:0]        nxt_s;
  logic [ADDR_W-1:0] nxt_a;
  logic [ADDR_W-1:0] nxt_b;
  logic [ADDR_W-2:0] nxt_tw;
  logic [2:0]        nxt_mode;

  // Insert a zero at bit ss of the butterfly index to get the top address.
  function automatic logic [ADDR_W-1:0] calc_a(input logic [ADDR_W-2:0] kk,
                                               input logic [3:0] ss);
    logic [ADDR_W-1:0] kw;
    logic [ADDR_W-1:0] mask;
    kw   = {1'b0, kk};
    mask = (ADDR_W'(1) << ss) - ADDR_W'(1);
    return ((kw & ~mask) << 1) | (kw & mask);
  endfunction

  function automatic logic [ADDR_W-2:0] calc_tw(input logic [ADDR_W-2:0] kk,
                                                input logic [3:0] ss);
    logic [ADDR_W-2:0] mask;
    mask = ((ADDR_W-1)'(1) << ss) - (ADDR_W-1)'(1);
    return (kk & mask) << (LAST_S - ss);
  endfunction

  function automatic logic [2:0] calc_mode(input logic [ADDR_W-2:0] tw);
    if (tw == '0)
      return 3'b000;
    else if (tw == QUARTER)
      return 3'b001;
    else
      return 3'b100;
  endfunction

  // Next butterfly is precomputed so every output can be registered.
  always_comb begin
    wrap_k   = (k == '1);
    is_last  = wrap_k && (s == LAST_S);
    nxt_k    = k + (ADDR_W-1)'(1);
    nxt_s    = wrap_k ? s + 4'd1 : s;
    nxt_a    = calc_a(nxt_k, nxt_s);
    nxt_b    = nxt_a | (ADDR_W'(1) << nxt_s);
    nxt_tw   = calc_tw(nxt_k, nxt_s);
    nxt_mode = calc_mode(nxt_tw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      s             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.addr_a    <= '0;
      bus.addr_b    <= '0;
      bus.tw_addr   <= '0;
      bus.stage     <= '0;
      bus.mode      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            k             <= '0;
            s             <= '0;
            busy          <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.addr_a    <= '0;
            bus.addr_b    <= ADDR_W'(1);
            bus.tw_addr   <= '0;
            bus.stage     <= '0;
            bus.mode      <= 3'b000;
          end
        end
        RUN: begin
          if (bus.out_valid && bus.out_ready) begin
            if (is_last) begin
              state         <= DONE;
              k             <= '0;
              s             <= '0;
              busy          <= 1'b0;
              done          <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.addr_a    <= '0;
              bus.addr_b    <= '0;
              bus.tw_addr   <= '0;
              bus.stage     <= '0;
              bus.mode      <= '0;
            end else begin
              k           <= nxt_k;
              s           <= nxt_s;
              bus.addr_a  <= nxt_a;
              bus.addr_b  <= nxt_b;
              bus.tw_addr <= nxt_tw;
              bus.stage   <= nxt_s;
              bus.mode    <= nxt_mode;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: an N=8 instance against hand-written butterfly
// tables, plus an N=1024 instance under random backpressure.
module tb_fft_addr_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic s_start, s_busy, s_done;
  logic l_start, l_busy, l_done;

  int n_asserts = 0;
  int n_fail    = 0;
  int s_xfer_cnt = 0, s_done_cnt = 0;
  int l_xfer_cnt = 0, l_done_cnt = 0;

  // Hand-derived N=8 butterfly sequence (stage = index/4).
  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int exp_md [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 4, 1, 4};

  bit seen [0:9][0:1023];

  fft_addr_gen_if #(.LOG_N(3))  s_bus ();
  fft_addr_gen_if #(.LOG_N(10)) l_bus ();

  fft_addr_gen #(.LOG_N(3)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s_start),
    .busy  (s_busy),
    .done  (s_done),
    .bus   (s_bus)
  );

  fft_addr_gen #(.LOG_N(10)) dut_large (
    .clk   (clk),
    .rst_n (rst_n),
    .start (l_start),
    .busy  (l_busy),
    .done  (l_done),
    .bus   (l_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_bus.out_valid && s_bus.out_ready) s_xfer_cnt++;
    if (s_done) s_done_cnt++;
    if (l_bus.out_valid && l_bus.out_ready) l_xfer_cnt++;
    if (l_done) l_done_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_tuple(input string tag, input int i);
    check_output({tag, "_valid"}, 32'(s_bus.out_valid), 32'd1);
    check_output({tag, "_busy"},  32'(s_busy),          32'd1);
    check_output({tag, "_done"},  32'(s_done),          32'd0);
    check_output({tag, "_addr_a"}, 32'(s_bus.addr_a),  32'(exp_a[i]));
    check_output({tag, "_addr_b"}, 32'(s_bus.addr_b),  32'(exp_b[i]));
    check_output({tag, "_tw"},     32'(s_bus.tw_addr), 32'(exp_tw[i]));
    check_output({tag, "_mode"},   32'(s_bus.mode),    32'(exp_md[i]));
    check_output({tag, "_stage"},  32'(s_bus.stage),   32'(i / 4));
  endtask

  task automatic check_small_zero(input string tag);
    check_output({tag, "_valid"},  32'(s_bus.out_valid), 32'd0);
    check_output({tag, "_busy"},   32'(s_busy),          32'd0);
    check_output({tag, "_done"},   32'(s_done),          32'd0);
    check_output({tag, "_addr_a"}, 32'(s_bus.addr_a),    32'd0);
    check_output({tag, "_addr_b"}, 32'(s_bus.addr_b),    32'd0);
    check_output({tag, "_tw"},     32'(s_bus.tw_addr),   32'd0);
    check_output({tag, "_mode"},   32'(s_bus.mode),      32'd0);
    check_output({tag, "_stage"},  32'(s_bus.stage),     32'd0);
  endtask

  // Called at a negedge with the small instance idle; returns at a negedge in IDLE.
  task automatic run_transform(input string tag, input int stall_at,
                               input int stall_len, input bit poke_start);
    int bx, bd;
    bx = s_xfer_cnt;
    bd = s_done_cnt;
    s_start = 1'b1;
    s_bus.out_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == stall_at) begin
        s_bus.out_ready = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
          check_tuple({tag, "_hold"}, i);
          @(negedge clk);
        end
        s_bus.out_ready = 1'b1;
      end
      check_tuple(tag, i);
      if (poke_start && (i == 3 || i == 9)) s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
    end
    check_output({tag, "_done_pulse"}, 32'(s_done),          32'd1);
    check_output({tag, "_done_valid"}, 32'(s_bus.out_valid), 32'd0);
    check_output({tag, "_done_busy"},  32'(s_busy),          32'd0);
    if (poke_start) s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check_output({tag, "_idle_done"},  32'(s_done),          32'd0);
    check_output({tag, "_idle_valid"}, 32'(s_bus.out_valid), 32'd0);
    check_output({tag, "_idle_busy"},  32'(s_busy),          32'd0);
    check_output({tag, "_xfers"},      32'(s_xfer_cnt - bx), 32'd12);
    check_output({tag, "_done_count"}, 32'(s_done_cnt - bd), 32'd1);
  endtask

  initial begin
    int bd, ls, g, j, span, xfers, cyc, e_a, e_tw, e_md;

    rst_n = 1'b0;
    s_start = 1'b0;
    l_start = 1'b0;
    s_bus.out_ready = 1'b0;
    l_bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    check_small_zero("reset");
    check_output("reset_large_valid", 32'(l_bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_small_zero("post_reset_idle");

    $display("[TB] full transform, ready held high");
    run_transform("seq", -1, 0, 1'b0);

    $display("[TB] back-to-back start after DONE");
    run_transform("b2b", -1, 0, 1'b0);

    $display("[TB] backpressure at s1,k1");
    run_transform("stall", 5, 5, 1'b0);

    $display("[TB] start pulsed during RUN and DONE");
    run_transform("poke", -1, 0, 1'b1);

    $display("[TB] async reset mid-run");
    bd = s_done_cnt;
    s_start = 1'b1;
    s_bus.out_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (5) @(negedge clk);
    check_tuple("pre_reset", 5);
    rst_n = 1'b0;
    #1;
    check_small_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_small_zero("after_reset_idle");
    check_output("reset_no_done", 32'(s_done_cnt - bd), 32'd0);
    run_transform("after_reset", -1, 0, 1'b0);

    $display("[TB] N=1024 with random ready");
    bd = l_done_cnt;
    ls = 0; g = 0; j = 0; xfers = 0; cyc = 0;
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    while (xfers < 5120 && cyc < 40000) begin
      span = 1 << ls;
      e_a  = g * 2 * span + j;
      e_tw = j * (512 / span);
      e_md = (e_tw == 0) ? 0 : ((e_tw == 256) ? 1 : 4);
      check_output("big_valid",  32'(l_bus.out_valid), 32'd1);
      check_output("big_addr_a", 32'(l_bus.addr_a),    32'(e_a));
      check_output("big_span",   32'(l_bus.addr_b) - 32'(l_bus.addr_a), 32'(span));
      check_output("big_tw",     32'(l_bus.tw_addr),   32'(e_tw));
      check_output("big_mode",   32'(l_bus.mode),      32'(e_md));
      check_output("big_stage",  32'(l_bus.stage),     32'(ls));
      l_bus.out_ready = 1'($urandom_range(0, 1));
      if (l_bus.out_ready) begin
        check_output("big_unique", 32'(seen[ls][l_bus.addr_a]), 32'd0);
        seen[ls][l_bus.addr_a] = 1'b1;
        xfers++;
        j++;
        if (j == span) begin
          j = 0;
          g++;
          if (g == 512 / span) begin
            g = 0;
            ls++;
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
    l_bus.out_ready = 1'b0;
    check_output("big_xfers_model", 32'(xfers), 32'd5120);
    check_output("big_xfers_seen",  32'(l_xfer_cnt), 32'd5120);
    check_output("big_done_pulse",  32'(l_done), 32'd1);
    check_output("big_done_valid",  32'(l_bus.out_valid), 32'd0);
    check_output("big_done_busy",   32'(l_busy), 32'd0);
    repeat (3) @(negedge clk);
    check_output("big_done_low",    32'(l_done), 32'd0);
    check_output("big_done_count",  32'(l_done_cnt - bd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
